sd_block_reader: RTL and testbench
==================================

SD_BLOCK_READER -- requirements
Module: sd_block_reader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h00100000, first SD block address read by the test.
REQ-002 SHALL have parameter BLOCK_BYTES, default 512, bytes consumed per block.
REQ-003 SHALL have port clk  input  1  sole clock; every register updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port start  input  1  level request; held high for the whole test and qualified every cycle.
REQ-006 SHALL have port n_blocks  input  32  number of blocks to read, sampled on leaving IDLE.
REQ-007 SHALL have port sclk_speed  input  5  SPI clock divider select, sampled on leaving IDLE.
REQ-008 SHALL have port cmd18  input  1  1 = one multi-block read (CMD18); 0 = repeated single-block reads (CMD17); sampled on leaving IDLE.
REQ-009 SHALL have port spi_busy  input  1  SD SPI host busy.
REQ-010 SHALL have port spi_err  input  1  SD SPI host error.
REQ-011 SHALL have port spi_data_out  input  8  byte returned by the host, valid when spi_busy falls after a byte request.
REQ-012 SHALL have port spi_block_addr  output  32  block address presented to the host.
REQ-013 SHALL have ports spi_r_block, spi_r_multi_block, spi_r_byte  output  1 each  host read requests.
REQ-014 SHALL have port spi_sclk_speed  output  5  registered copy of sclk_speed.
REQ-015 SHALL have port finish  output  1  test complete, success or error.
REQ-016 SHALL have port err  output  1  test aborted by spi_err.
REQ-017 SHALL have port blocks_done  output  32  fully consumed block count.
REQ-018 SHALL have port checksum  output  32  running byte sum (see Configuration).

Function
REQ-019 SHALL implement states IDLE, START_BLK, WAIT_BLK, REQ_BYTE, WAIT_BYTE, NEXT_BLK, DONE, ERROR.
REQ-020 IDLE: outputs inactive; start=1 latches n_blocks, sclk_speed and cmd18, clears counters and checksum, then goes to DONE if n_blocks==0, otherwise to START_BLK.
REQ-021 START_BLK: spi_r_block=1 (single mode) or spi_r_multi_block=1 (multi mode); moves to WAIT_BLK on spi_busy=1.
REQ-022 WAIT_BLK: request held; moves to REQ_BYTE on spi_busy=0.
REQ-023 REQ_BYTE: block request held plus spi_r_byte=1; on spi_busy=1, byte counter increments and the state moves to WAIT_BYTE.
REQ-024 WAIT_BYTE: block request held; on spi_busy=0, spi_data_out is consumed, then the state moves to NEXT_BLK if byte counter==BLOCK_BYTES, otherwise to REQ_BYTE.
REQ-025 NEXT_BLK: blocks_done increments and the byte counter clears, then the state moves to DONE if blocks_done+1==latched n_blocks; otherwise single mode drops spi_r_block for this cycle and goes to START_BLK, and multi mode keeps spi_r_multi_block high and goes to WAIT_BLK after spi_busy=1.
REQ-026 spi_block_addr SHALL equal BASE_ADDR+blocks_done in single mode, and BASE_ADDR for the whole test in multi mode; the 32-bit sum wraps modulo 2^32.
REQ-027 DONE: finish=1, all requests 0; stays until start=0, then goes to IDLE.
REQ-028 spi_err=1 in any state other than IDLE, DONE or ERROR SHALL move to ERROR next cycle: err=1, finish=1, requests 0, held until start=0.
REQ-029 start=0 in any active state SHALL abort to IDLE next cycle with all requests deasserted; blocks_done and checksum keep their last values.
REQ-030 When spi_err and start=0 occur in the same cycle, the abort to IDLE SHALL take priority.
REQ-031 blocks_done SHALL saturate at 32'hFFFFFFFF; the byte counter is 10 bits.

Reset
REQ-032 rst=1 SHALL force IDLE and zero every output, counter and latched parameter on the next rising clk edge.
REQ-033 rst SHALL take priority over every other input, including in the middle of a block.

Configuration
REQ-034 Macro SD_BLOCK_READER_CHECKSUM_EN defined: checksum accumulates each consumed byte, zero-extended, modulo 2^32; it clears on leaving IDLE and holds in DONE and ERROR.
REQ-035 Macro undefined: checksum is tied to 32'h0 and no accumulator is synthesised.

Verification
REQ-036 Single mode, n_blocks=2, host model returns byte index&8'hFF -> addresses 0x00100000 then 0x00100001, blocks_done=2, finish=1, checksum=2*0xFF00 (macro on).
REQ-037 Multi mode, n_blocks=3 -> spi_r_multi_block high throughout, spi_block_addr=0x00100000 constant, 1536 spi_r_byte handshakes, finish=1.
REQ-038 n_blocks=0, start=1 -> finish=1 two cycles after start, with no spi_r_* asserted.
REQ-039 spi_err pulse at byte 100 of block 0 -> err=1, finish=1, blocks_done=0; start=0 -> IDLE.
REQ-040 start dropped at byte 300 of block 1 -> requests 0 next cycle, IDLE, blocks_done=1.
REQ-041 rst asserted in WAIT_BYTE -> every output 0 next cycle; a new start runs a full test correctly.

Source files
------------

// File: rtl/sd_block_reader.sv
// sd_block_reader: reads n_blocks SD blocks of BLOCK_BYTES bytes through an
// SD SPI host. It uses either repeated single-block reads (CMD17) or one
// multi-block read (CMD18).
//
// Optional feature: define SD_BLOCK_READER_CHECKSUM_EN to add a running
// 32-bit byte sum on 'checksum'. Without it, 'checksum' is tied to zero.
//
// Host handshake: a request (spi_r_block / spi_r_multi_block / spi_r_byte)
// is a level. The host acknowledges it by raising spi_busy. The operation
// completes when spi_busy falls. On that fall, spi_data_out carries the byte
// for a byte request. Requests stay asserted until the acknowledge is seen.
// They never drop while the host is busy, except on abort, error or reset.
`timescale 1ns/1ps

module sd_block_reader #(
  parameter logic [31:0] BASE_ADDR   = 32'h00100000,
  parameter int unsigned BLOCK_BYTES = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] n_blocks,
  input  logic [4:0]  sclk_speed,
  input  logic        cmd18,
  input  logic        spi_busy,
  input  logic        spi_err,
  input  logic [7:0]  spi_data_out,
  output logic [31:0] spi_block_addr,
  output logic        spi_r_block,
  output logic        spi_r_multi_block,
  output logic        spi_r_byte,
  output logic [4:0]  spi_sclk_speed,
  output logic        finish,
  output logic        err,
  output logic [31:0] blocks_done,
  output logic [31:0] checksum,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START_BLK = 3'd1,
    S_WAIT_BLK  = 3'd2,
    S_REQ_BYTE  = 3'd3,
    S_WAIT_BYTE = 3'd4,
    S_NEXT_BLK  = 3'd5,
    S_DONE      = 3'd6,
    S_ERROR     = 3'd7
  } state_t;

  // The byte counter is 10 bits wide, so the block length is compared in that width.
  localparam logic [9:0] LP_BLOCK_BYTES = 10'(BLOCK_BYTES);

  state_t      r_state;
  logic [31:0] r_n_blocks;
  logic        r_cmd18;
  logic [4:0]  r_sclk;
  logic [9:0]  r_byte_cnt;
  logic [31:0] r_blocks_done;
  logic [31:0] r_addr;
  logic        r_req_block;
  logic        r_req_multi;
  logic        r_req_byte;
  logic        r_finish;
  logic        r_err;

  logic        w_leave_idle;
  logic        w_consume;
  logic        w_block_end;
  logic [31:0] w_blocks_inc;

  // A new test begins when start is seen in IDLE.
  assign w_leave_idle = (r_state == S_IDLE) && start;

  // A byte is consumed when the host finishes a byte read. Abort and error take precedence.
  assign w_consume = (r_state == S_WAIT_BYTE) && start && !spi_err && !spi_busy;

  // The last byte of the current block has been consumed.
  assign w_block_end = w_consume && (r_byte_cnt == LP_BLOCK_BYTES);

  // The completed-block count saturates instead of wrapping.
  assign w_blocks_inc = (r_blocks_done == 32'hFFFF_FFFF) ? r_blocks_done
                                                         : r_blocks_done + 32'd1;

  // Main sequencer: state, latched test parameters, counters and registered host requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_n_blocks    <= '0;
      r_cmd18       <= 1'b0;
      r_sclk        <= '0;
      r_byte_cnt    <= '0;
      r_blocks_done <= '0;
      r_addr        <= '0;
      r_req_block   <= 1'b0;
      r_req_multi   <= 1'b0;
      r_req_byte    <= 1'b0;
      r_finish      <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n_blocks    <= n_blocks;
            r_cmd18       <= cmd18;
            r_sclk        <= sclk_speed;
            r_byte_cnt    <= '0;
            r_blocks_done <= '0;
            r_addr        <= BASE_ADDR;
            r_err         <= 1'b0;
            if (n_blocks == 32'd0) begin
              r_state  <= S_DONE;
              r_finish <= 1'b1;
            end else begin
              r_state     <= S_START_BLK;
              r_req_block <= !cmd18;
              r_req_multi <= cmd18;
            end
          end
        end

        // Both terminal states hold their flags until the requester lets go.
        S_DONE, S_ERROR: begin
          if (!start) begin
            r_state  <= S_IDLE;
            r_finish <= 1'b0;
            r_err    <= 1'b0;
          end
        end

        default: begin
          if (!start) begin
            // Abort: drop every request. Progress counters keep their values.
            r_state     <= S_IDLE;
            r_req_block <= 1'b0;
            r_req_multi <= 1'b0;
            r_req_byte  <= 1'b0;
          end else if (spi_err) begin
            r_state     <= S_ERROR;
            r_req_block <= 1'b0;
            r_req_multi <= 1'b0;
            r_req_byte  <= 1'b0;
            r_finish    <= 1'b1;
            r_err       <= 1'b1;
          end else begin
            case (r_state)
              S_START_BLK: begin
                if (spi_busy) r_state <= S_WAIT_BLK;
              end

              S_WAIT_BLK: begin
                if (!spi_busy) begin
                  r_state    <= S_REQ_BYTE;
                  r_req_byte <= 1'b1;
                end
              end

              S_REQ_BYTE: begin
                if (spi_busy) begin
                  r_state    <= S_WAIT_BYTE;
                  r_req_byte <= 1'b0;
                  r_byte_cnt <= r_byte_cnt + 10'd1;
                end
              end

              S_WAIT_BYTE: begin
                if (w_block_end) begin
                  r_state       <= S_NEXT_BLK;
                  r_byte_cnt    <= '0;
                  r_blocks_done <= w_blocks_inc;
                  if (!r_cmd18) begin
                    // Single-block mode releases the request between blocks.
                    r_req_block <= 1'b0;
                    r_addr      <= BASE_ADDR + w_blocks_inc;
                  end
                end else if (w_consume) begin
                  r_state    <= S_REQ_BYTE;
                  r_req_byte <= 1'b1;
                end
              end

              S_NEXT_BLK: begin
                if (r_blocks_done == r_n_blocks) begin
                  r_state     <= S_DONE;
                  r_req_block <= 1'b0;
                  r_req_multi <= 1'b0;
                  r_finish    <= 1'b1;
                end else if (!r_cmd18) begin
                  r_state     <= S_START_BLK;
                  r_req_block <= 1'b1;
                end else if (spi_busy) begin
                  // Multi-block mode: the host signals the next data token.
                  r_state <= S_WAIT_BLK;
                end
              end

              default: begin
                r_state     <= S_IDLE;
                r_req_block <= 1'b0;
                r_req_multi <= 1'b0;
                r_req_byte  <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

`ifdef SD_BLOCK_READER_CHECKSUM_EN
  logic [31:0] r_checksum;

  // Running zero-extended byte sum, cleared at the start of each test.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_checksum <= '0;
    end else if (w_leave_idle) begin
      r_checksum <= '0;
    end else if (w_consume) begin
      r_checksum <= r_checksum + {24'h0, spi_data_out};
    end
  end

  assign checksum = r_checksum;
`else
  logic w_unused_sum;

  // Without the accumulator, the byte data and its consume strobe have no sink.
  assign w_unused_sum = ^{spi_data_out, w_consume, w_leave_idle};
  assign checksum     = 32'h0;
`endif

  assign spi_block_addr    = r_addr;
  assign spi_r_block       = r_req_block;
  assign spi_r_multi_block = r_req_multi;
  assign spi_r_byte        = r_req_byte;
  assign spi_sclk_speed    = r_sclk;
  assign finish            = r_finish;
  assign err               = r_err;
  assign blocks_done       = r_blocks_done;
  assign dbg_state         = r_state;

endmodule

// File: tb/tb_sd_block_reader.sv
// Bench for sd_block_reader.
// A reactive SD SPI host model serves the block and byte requests with
// random latency and random or patterned data. A scoreboard holds the
// expected block addresses. Expected counts and sums come from the host's
// own record of what it delivered.
`timescale 1ns/1ps

module tb_sd_block_reader;

  localparam logic [31:0] BASE         = 32'h00100000;
  localparam int          BB           = 512;
  localparam logic [2:0]  ST_WAIT_BYTE = 3'd4;
  localparam int          BUDGET       = 20000;
`ifdef SD_BLOCK_READER_CHECKSUM_EN
  localparam bit CKS_EN = 1'b1;
`else
  localparam bit CKS_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] n_blocks;
  logic [4:0]  sclk_speed;
  logic        cmd18;
  logic        spi_busy;
  logic        spi_err;
  logic [7:0]  spi_data_out;
  logic [31:0] spi_block_addr;
  logic        spi_r_block;
  logic        spi_r_multi_block;
  logic        spi_r_byte;
  logic [4:0]  spi_sclk_speed;
  logic        finish;
  logic        err;
  logic [31:0] blocks_done;
  logic [31:0] checksum;
  logic [2:0]  dbg_state;

  sd_block_reader #(.BASE_ADDR(BASE), .BLOCK_BYTES(BB)) dut (
    .clk(clk), .rst(rst), .start(start), .n_blocks(n_blocks),
    .sclk_speed(sclk_speed), .cmd18(cmd18), .spi_busy(spi_busy),
    .spi_err(spi_err), .spi_data_out(spi_data_out),
    .spi_block_addr(spi_block_addr), .spi_r_block(spi_r_block),
    .spi_r_multi_block(spi_r_multi_block), .spi_r_byte(spi_r_byte),
    .spi_sclk_speed(spi_sclk_speed), .finish(finish), .err(err),
    .blocks_done(blocks_done), .checksum(checksum), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_sum;

  // host model state
  int          h_cnt;
  int          h_bytes_total;
  int          h_blk_bytes;
  int          h_blk_done;
  bit          h_op_byte;
  bit          h_open;
  bit          h_aborted;
  logic [7:0]  h_data;
  bit          data_rand;
  int          evt_at;
  int          evt_kind;   // 1 = spi_err pulse, 2 = drop start, 3 = both
  bit          cur_cmd18;
  bit          mon_on;
  bit          mon_multi_seen;
  int          multi_gap;
  int          bad_req;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_cks();
    return CKS_EN ? exp_sum : 32'h0;
  endfunction

  // ---------------- host model (acts 2ns after each rising edge) ----------------
  initial begin
    spi_busy = 1'b0; spi_err = 1'b0; spi_data_out = 8'h00;
    h_cnt = 0; h_open = 0; h_op_byte = 0; h_data = 8'h00;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        spi_busy = 1'b0; spi_err = 1'b0; h_cnt = 0; h_open = 0;
      end else begin
        if (mon_on) begin
          if (cur_cmd18 ? spi_r_block : spi_r_multi_block) bad_req++;
          if (cur_cmd18 && mon_multi_seen && !finish && !h_aborted && !spi_r_multi_block) multi_gap++;
          if (spi_r_multi_block) mon_multi_seen = 1;
        end
        spi_err = 1'b0;
        if (h_cnt > 0) begin
          h_cnt--;
          if (h_cnt == 0) begin
            spi_busy = 1'b0;
            if (h_op_byte) begin
              spi_data_out = h_data;
              exp_sum += {24'h0, h_data};
              h_bytes_total++;
              h_blk_bytes++;
              if (h_blk_bytes == BB) begin
                h_blk_bytes = 0; h_blk_done++; h_open = 0;
              end
            end
          end
        end else if (!(spi_r_block || spi_r_multi_block)) begin
          h_open = 0;
        end else if (!h_open) begin
          if (exp_q.size() > 0) check_eq("block_addr", spi_block_addr, exp_q.pop_front());
          h_open = 1; h_op_byte = 0;
          spi_busy = 1'b1; h_cnt = $urandom_range(1, 2);
        end else if (spi_r_byte) begin
          if (h_bytes_total == evt_at) begin
            evt_at = -1;
            if (evt_kind != 2) spi_err = 1'b1;
            if (evt_kind != 1) begin start = 1'b0; h_aborted = 1; end
          end else begin
            h_data = data_rand ? 8'($urandom_range(0, 255)) : 8'(h_blk_bytes);
            h_op_byte = 1;
            spi_busy = 1'b1; h_cnt = $urandom_range(1, 2);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic prep(input int n, input bit c18, input bit drand);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(c18 ? BASE : BASE + 32'(i));
    h_bytes_total = 0; h_blk_bytes = 0; h_blk_done = 0; h_open = 0;
    h_aborted = 0; exp_sum = 32'h0; data_rand = drand; cur_cmd18 = c18;
    mon_on = 1; mon_multi_seen = 0; multi_gap = 0; bad_req = 0; evt_at = -1; evt_kind = 0;
  endtask

  task automatic launch(input int n, input bit c18, input logic [4:0] spd);
    n_blocks = 32'(n); cmd18 = c18; sclk_speed = spd; start = 1'b1;
  endtask

  task automatic wait_end(output int cyc);
    cyc = 0;
    while (!finish && !h_aborted && cyc < BUDGET) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic release_start(input int n_exp);
    start = 1'b0;
    @(posedge clk); #1;
    check_eq("idle_finish", finish, 1'b0);
    check_eq("idle_err", err, 1'b0);
    check_eq("idle_blocks_kept", blocks_done, 32'(n_exp));
    repeat (4) @(posedge clk);
    #1;
    mon_on = 0;
  endtask

  task automatic run_full(input int n, input bit c18, input bit drand);
    logic [4:0] spd;
    int cyc;
    spd = 5'($urandom_range(0, 31));
    prep(n, c18, drand);
    launch(n, c18, spd);
    @(posedge clk); #1;
    // These inputs are latched at launch; later changes must be ignored.
    n_blocks = 32'($urandom_range(5, 50)); cmd18 = ~c18; sclk_speed = ~spd;
    wait_end(cyc);
    check_eq("done_in_budget", cyc < BUDGET, 1'b1);
    check_eq("finish", finish, 1'b1);
    check_eq("err_clear", err, 1'b0);
    check_eq("reqs_in_done", {spi_r_block, spi_r_multi_block, spi_r_byte}, 3'b000);
    check_eq("blocks_done", blocks_done, 32'(n));
    check_eq("byte_handshakes", h_bytes_total, n * BB);
    check_eq("checksum", checksum, exp_cks());
    check_eq("sclk_speed", spi_sclk_speed, spd);
    check_eq("final_addr", spi_block_addr, c18 ? BASE : BASE + 32'(n));
    check_eq("addr_q_drained", exp_q.size(), 0);
    check_eq("mode_exclusive", bad_req, 0);
    check_eq("multi_held", multi_gap, 0);
    release_start(n);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    bit saw_req;
    logic [31:0] held;
    rst = 1'b1; start = 1'b0; n_blocks = '0; sclk_speed = '0; cmd18 = 1'b0;
    mon_on = 0; evt_at = -1; evt_kind = 0; h_aborted = 0; data_rand = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_finish", finish, 1'b0);
    check_eq("rst_reqs", {spi_r_block, spi_r_multi_block, spi_r_byte}, 3'b000);
    check_eq("rst_blocks", blocks_done, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single mode, two blocks, byte-index data.
    run_full(2, 1'b0, 1'b0);
    check_eq("cks_index_pattern", checksum, CKS_EN ? 32'h0001FE00 : 32'h0);

    // Multi mode, three blocks.
    run_full(3, 1'b1, 1'b0);

    // Zero blocks: finish without any request.
    prep(0, 1'b0, 1'b0);
    launch(0, 1'b0, 5'd7);
    saw_req = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (spi_r_block || spi_r_multi_block || spi_r_byte) saw_req = 1;
    end
    check_eq("zero_finish", finish, 1'b1);
    check_eq("zero_no_req", saw_req, 1'b0);
    check_eq("zero_blocks", blocks_done, 32'h0);
    release_start(0);

    // spi_err at byte 100 of block 0.
    prep(2, 1'b0, 1'b1);
    evt_at = 100; evt_kind = 1;
    launch(2, 1'b0, 5'd3);
    wait_end(cyc);
    check_eq("err_in_budget", cyc < BUDGET, 1'b1);
    check_eq("err_flag", err, 1'b1);
    check_eq("err_finish", finish, 1'b1);
    check_eq("err_blocks", blocks_done, 32'h0);
    check_eq("err_reqs", {spi_r_block, spi_r_multi_block, spi_r_byte}, 3'b000);
    check_eq("err_bytes", h_bytes_total, 100);
    check_eq("err_checksum", checksum, exp_cks());
    repeat (3) @(posedge clk);
    #1;
    check_eq("err_held", err, 1'b1);
    check_eq("err_cks_held", checksum, exp_cks());
    release_start(0);

    // start dropped at byte 300 of block 1.
    prep(3, 1'b0, 1'b1);
    evt_at = BB + 300; evt_kind = 2;
    launch(3, 1'b0, 5'd12);
    wait_end(cyc);
    check_eq("drop_in_budget", cyc < BUDGET, 1'b1);
    check_eq("drop_reqs", {spi_r_block, spi_r_multi_block, spi_r_byte}, 3'b000);
    check_eq("drop_finish", finish, 1'b0);
    check_eq("drop_blocks", blocks_done, 32'd1);
    check_eq("drop_checksum", checksum, exp_cks());
    held = checksum;
    repeat (3) @(posedge clk);
    #1;
    check_eq("drop_cks_kept", checksum, held);
    check_eq("drop_blocks_kept", blocks_done, 32'd1);
    mon_on = 0;

    // spi_err and start=0 together: the abort wins.
    prep(2, 1'b1, 1'b1);
    evt_at = BB + 188; evt_kind = 3;
    launch(2, 1'b1, 5'd20);
    wait_end(cyc);
    check_eq("prio_in_budget", cyc < BUDGET, 1'b1);
    check_eq("prio_err", err, 1'b0);
    check_eq("prio_finish", finish, 1'b0);
    check_eq("prio_reqs", {spi_r_block, spi_r_multi_block, spi_r_byte}, 3'b000);
    check_eq("prio_blocks", blocks_done, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    mon_on = 0;

    // Reset in WAIT_BYTE during block 1, then a clean full run.
    prep(2, 1'b1, 1'b1);
    launch(2, 1'b1, 5'd9);
    cyc = 0;
    while (!(dbg_state == ST_WAIT_BYTE && h_bytes_total >= 600) && cyc < BUDGET) begin
      @(posedge clk); #1; cyc++;
    end
    check_eq("rst_point_reached", cyc < BUDGET, 1'b1);
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_rst_reqs", {spi_r_block, spi_r_multi_block, spi_r_byte}, 3'b000);
    check_eq("mid_rst_flags", {finish, err}, 2'b00);
    check_eq("mid_rst_blocks", blocks_done, 32'h0);
    check_eq("mid_rst_addr", spi_block_addr, 32'h0);
    check_eq("mid_rst_sclk", spi_sclk_speed, 5'h0);
    check_eq("mid_rst_cks", checksum, 32'h0);
    rst = 1'b0;
    mon_on = 0;
    repeat (3) @(posedge clk);
    #1;
    run_full(2, 1'b0, 1'b1);

    // Randomized runs.
    repeat (3) run_full($urandom_range(1, 3), 1'($urandom_range(0, 1)), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
